count_seq_monitor: RTL
======================

Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit custom-sequence counter in the counters area.
- Samples the counter's q bus and checks it against the programmed 4-state cycle. Default cycle: 000 -> 101 -> 100 -> 110 -> 000.
- Reports lock, fault, sequence phase and a saturating error count for debug LEDs and self-check benches.

Parameters:
- SEQ0, 3'b000, first legal count value (sequence start after counter reset).
- SEQ1, 3'b101, second legal value.
- SEQ2, 3'b100, third legal value.
- SEQ3, 3'b110, fourth legal value; successor is SEQ0.
- LOCK_N, 4, consecutive legal samples needed to declare lock (range 1..15).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_en  in  1  qualifies count_in for this cycle.
- count_in  in  3  counter q output.
- clear_fault  in  1  one-cycle pulse; leaves FAULT.
- locked  out  1  high while FSM in LOCKED.
- fault  out  1  high while FSM in FAULT.
- phase  out  2  index (0..3) of the last legal sample.
- last_bad  out  3  value of the most recent offending sample.
- err_count  out  ERR_W  saturating count of offending samples.

Behaviour:
- Clock and reset: reset is synchronous, active-low; clock is clk.
- Reset values (reset==0 at an edge): FSM=SEARCH, locked=0, fault=0, phase=0, last_bad=0, err_count=0, prev_valid=0, match_cnt=0.
- Reset mid-operation: takes effect on the same edge and overrides everything, including sample_en and clear_fault.
- SEQ0..SEQ3 must be distinct. A repeated value (stuck counter) is therefore always an illegal transition.
- Legal value: count_in equals one of SEQ0..SEQ3.
- Legal transition: prev_valid=1 and count_in equals succ(prev). succ wraps SEQ3 -> SEQ0.
- Sampling:
  - Only edges with sample_en=1 are evaluated.
  - With sample_en=0, all state holds.
  - On an evaluated edge, prev <= count_in and prev_valid <= 1.
- FSM: states SEARCH, ACQUIRE, LOCKED, FAULT. All outputs are registered and change on the evaluating edge (zero added latency).
- SEARCH:
  - Legal value -> ACQUIRE, match_cnt=1.
  - If LOCK_N=1, go directly to LOCKED instead.
  - Illegal value -> stay in SEARCH; no error is counted.
- ACQUIRE:
  - Legal transition: match_cnt+1. When it reaches LOCK_N -> LOCKED.
  - Legal value with illegal transition: restart ACQUIRE, match_cnt=1.
  - Illegal value -> SEARCH, match_cnt=0.
  - No errors are counted in ACQUIRE.
- LOCKED:
  - Legal transition -> stay.
  - Anything else -> FAULT, last_bad <= count_in, err_count +1.
- FAULT:
  - Holds until clear_fault.
  - Every further evaluated sample that is not a legal transition increments err_count and updates last_bad.
- err_count saturates at all-ones and never wraps. Only reset clears it.
- phase updates to the index of count_in on every legal-value sample in any state. It holds otherwise.
- clear_fault:
  - Honoured in FAULT only. Next state is SEARCH, match_cnt=0, prev_valid=0.
  - A sample on the same edge is ignored: no error counted, last_bad unchanged.
  - In any other state clear_fault has no effect.

Test Plan:
- Reset then sample 000,101,100,110 -> locked rises on the 4th sampling edge; phase=0,1,2,3; err_count=0.
- Locked, then samples 000,101,111 -> on the 111 edge: fault=1, locked=0, last_bad=3'b111, err_count=1.
- In FAULT, feed 3 more bad samples (011,011,011), then pulse clear_fault alongside a bad 010 -> err_count=4, last_bad=011, state SEARCH. Relock with 000,101,100,110 -> locked=1.
- Locked, hold count_in=100 for two samples (stuck) -> fault on the second 100 edge, last_bad=100.
- sample_en=0 for 10 cycles while count_in toggles illegal values -> no state or output change. Force 300 bad samples in FAULT -> err_count=255, holding.
- Assert reset low mid-ACQUIRE (after 000,101) -> all outputs zero next edge. The 100,110 that follow do not lock; full 4-sample acquisition is required.

Source files
------------

// File: rtl/count_seq_if.sv
// count_seq_if: bundles the sample-side inputs and status outputs of count_seq_monitor.
//
//   master : drives sample_en, count_in and clear_fault; observes the status outputs
//   slave  : the monitor; consumes the sample inputs and drives the status outputs
//
//   sample_en    qualifies count_in for this cycle
//   count_in     3-bit counter q value being watched
//   clear_fault  one-cycle pulse that releases FAULT
//   locked       monitor is in LOCKED
//   fault        monitor is in FAULT
//   phase        index 0..3 of the last legal sample
//   last_bad     most recent offending sample
//   err_count    saturating count of offending samples
interface count_seq_if #(
    parameter int unsigned ERR_W = 8
);
    logic             sample_en;
    logic [2:0]       count_in;
    logic             clear_fault;
    logic             locked;
    logic             fault;
    logic [1:0]       phase;
    logic [2:0]       last_bad;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sample_en,
        output count_in,
        output clear_fault,
        input  locked,
        input  fault,
        input  phase,
        input  last_bad,
        input  err_count
    );

    modport slave (
        input  sample_en,
        input  count_in,
        input  clear_fault,
        output locked,
        output fault,
        output phase,
        output last_bad,
        output err_count
    );
endinterface

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: watches a 3-bit custom-sequence counter and checks that it walks the
// programmed 4-value cycle SEQ0 -> SEQ1 -> SEQ2 -> SEQ3 -> SEQ0.
//
// Ports:
//   clk     rising-edge clock for all state
//   reset   synchronous, active-low reset
//   mon_io  count_seq_if.slave: sample_en/count_in/clear_fault in,
//           locked/fault/phase/last_bad/err_count out
//
// The monitor searches for any legal value, then needs LOCK_N consecutive legal samples
// (each a legal successor of the previous one) to lock. Once locked, any sample that is not
// the legal successor drops it into FAULT, where it stays until clear_fault, counting every
// further offending sample in a saturating error counter.
module count_seq_monitor #(
    parameter logic [2:0]  SEQ0   = 3'b000,
    parameter logic [2:0]  SEQ1   = 3'b101,
    parameter logic [2:0]  SEQ2   = 3'b100,
    parameter logic [2:0]  SEQ3   = 3'b110,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERR_W  = 8
) (
    input logic        clk,
    input logic        reset,
    count_seq_if.slave mon_io
);

    // Elaboration-time sanity checks on the parameter set.
    if (LOCK_N < 1 || LOCK_N > 15) begin : g_bad_lock_n
        $error("count_seq_monitor: LOCK_N must be in 1..15");
    end
    if (SEQ0 == SEQ1 || SEQ0 == SEQ2 || SEQ0 == SEQ3 ||
        SEQ1 == SEQ2 || SEQ1 == SEQ3 || SEQ2 == SEQ3) begin : g_bad_seq
        $error("count_seq_monitor: SEQ0..SEQ3 must be distinct");
    end

    localparam logic [3:0] LockN = 4'(LOCK_N);

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [2:0]       prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       last_bad_q, last_bad_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             cur_legal;
    logic [1:0]       cur_idx;
    logic             prev_legal;
    logic [1:0]       prev_idx;
    logic             legal_trans;
    logic [ERR_W-1:0] err_count_inc;

    function automatic logic [2:0] seq_val(input logic [1:0] idx);
        logic [2:0] v;
        unique case (idx)
            2'd0:    v = SEQ0;
            2'd1:    v = SEQ1;
            2'd2:    v = SEQ2;
            default: v = SEQ3;
        endcase
        return v;
    endfunction

    // Map the current and previous samples onto their sequence indices.
    always_comb begin
        cur_legal  = 1'b0;
        cur_idx    = 2'd0;
        prev_legal = 1'b0;
        prev_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (mon_io.count_in == seq_val(2'(i))) begin
                cur_legal = 1'b1;
                cur_idx   = 2'(i);
            end
            if (prev_q == seq_val(2'(i))) begin
                prev_legal = 1'b1;
                prev_idx   = 2'(i);
            end
        end
    end

    // Index arithmetic wraps naturally, so SEQ3's successor is SEQ0. A repeated value can
    // never be a successor because the four values are distinct.
    assign legal_trans = prev_valid_q && prev_legal &&
                         (mon_io.count_in == seq_val(prev_idx + 2'd1));

    assign err_count_inc = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                           : err_count_q + ERR_W'(1);

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        phase_d      = phase_q;
        last_bad_d   = last_bad_q;
        err_count_d  = err_count_q;

        if (state_q == StFault && mon_io.clear_fault) begin
            // Release wins over any sample on the same edge; that sample is dropped entirely.
            state_d      = StSearch;
            match_cnt_d  = 4'd0;
            prev_valid_d = 1'b0;
        end else if (mon_io.sample_en) begin
            prev_d       = mon_io.count_in;
            prev_valid_d = 1'b1;
            if (cur_legal) begin
                phase_d = cur_idx;
            end

            unique case (state_q)
                StSearch: begin
                    if (cur_legal) begin
                        match_cnt_d = 4'd1;
                        state_d     = (LockN == 4'd1) ? StLocked : StAcquire;
                    end
                end
                StAcquire: begin
                    if (legal_trans) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d >= LockN) begin
                            state_d = StLocked;
                        end
                    end else if (cur_legal) begin
                        // Legal value out of order: this sample starts a fresh run.
                        match_cnt_d = 4'd1;
                    end else begin
                        state_d     = StSearch;
                        match_cnt_d = 4'd0;
                    end
                end
                StLocked: begin
                    if (!legal_trans) begin
                        state_d     = StFault;
                        last_bad_d  = mon_io.count_in;
                        err_count_d = err_count_inc;
                    end
                end
                StFault: begin
                    if (!legal_trans) begin
                        last_bad_d  = mon_io.count_in;
                        err_count_d = err_count_inc;
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StSearch;
            match_cnt_q  <= 4'd0;
            prev_q       <= 3'd0;
            prev_valid_q <= 1'b0;
            phase_q      <= 2'd0;
            last_bad_q   <= 3'd0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            phase_q      <= phase_d;
            last_bad_q   <= last_bad_d;
            err_count_q  <= err_count_d;
        end
    end

    // Outputs decode straight from registers, so they move on the evaluating edge.
    assign mon_io.locked    = (state_q == StLocked);
    assign mon_io.fault     = (state_q == StFault);
    assign mon_io.phase     = phase_q;
    assign mon_io.last_bad  = last_bad_q;
    assign mon_io.err_count = err_count_q;

    // Once saturated the error count stays saturated until reset.
    a_err_sat_holds: assert property (@(posedge clk) disable iff (!reset)
        (err_count_q == {ERR_W{1'b1}}) |=> (err_count_q == {ERR_W{1'b1}}));

    // The acquisition counter never exceeds the lock threshold.
    a_match_bounded: assert property (@(posedge clk) disable iff (!reset)
        match_cnt_q <= LockN);

endmodule
